text_scan_controller: RTL
=========================

# text_scan_controller

Upstream feeder for `character_generator` in the LC3 video path. It generates 640x480 VGA raster timing and walks an 80x30 grid of 8x16-pixel character cells. It stores 4-bit character codes in an internal character RAM that the CPU side can write. Each pixel it presents `character`, `dot_count`, `scan_count` and `en` to `character_generator`, with `hsync_n`/`vsync_n`/`blank` delayed to line up with the generator's pixel output.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `PIXEL_LAT`, 1, downstream pixel latency in clk cycles, added to sync/blank delay

Ports:
- `clk` in 1: single system clock
- `rst` in 1: synchronous, active-high reset
- `px_en` in 1: pixel-clock enable; raster counters advance only when high
- `wr_en` in 1: character RAM write strobe
- `wr_addr` in 12: cell index, row*80+col
- `wr_data` in 4: character code
- `character` out 4: code of current cell, to `character_generator`
- `dot_count` out 3: pixel column within cell
- `scan_count` out 4: pixel row within cell
- `en` out 1: enable to `character_generator`
- `hsync_n` out 1: active-low horizontal sync, delayed
- `vsync_n` out 1: active-low vertical sync, delayed
- `blank` out 1: high outside the active area, delayed
- `frame_start` out 1: one-clk pulse when the raster returns to (0,0)

## Operation
- Derived constants:
  - H_TOTAL = 800, V_TOTAL = 525
  - COLS = H_ACTIVE/8 = 80, ROWS = V_ACTIVE/16 = 30
  - CELLS = 2400
- `h_cnt` (10b) and `v_cnt` (10b) step only on clk edges with `px_en` = 1.
  - `h_cnt` counts 0..799 and then wraps to 0.
  - `v_cnt` increments when `h_cnt` wraps, and wraps 524 -> 0 at `h_cnt` = 799.
- active = (`h_cnt` < 640) && (`v_cnt` < 480).
- Cell fields:
  - col = `h_cnt`[9:3], row = `v_cnt`[8:4]
  - dot = `h_cnt`[2:0], scan = `v_cnt`[3:0]
- Read address = row*80 + col, computed as (row<<6)+(row<<4)+col. No multiplier. Read address is used only while active.
- Raw sync, before delay:
  - hsync low for 656 <= `h_cnt` <= 751
  - vsync low for 490 <= `v_cnt` <= 491
- Character RAM: CELLS x 4 bits, one write port and one synchronous read port.
  - Writes with `wr_addr` >= 2400 are dropped.
  - Same-address read and write in one cycle: the read returns the old data.
  - Contents are not cleared by `rst`. The display shows whatever the RAM holds.
- `frame_start` pulses for exactly one clk when the counters step from (799,524) to (0,0).

## Timing
- Stage 0 holds the counters. Stage 1 holds the registered RAM read plus the registered `dot_count`, `scan_count` and `en`.
  - The counter state sampled at edge n appears on `character`/`dot_count`/`scan_count` after edge n+1 (1-clk latency).
  - `en` = registered (`px_en` && active), so it is high for exactly one clk per active pixel.
- `hsync_n`, `vsync_n` and `blank` pass through a shift register of 1+PIXEL_LAT clk stages, which aligns them with the `character_generator` pixel.
- Reset values:
  - `h_cnt` = `v_cnt` = 0
  - `character` = 0, `dot_count` = 0, `scan_count` = 0
  - `en` = 0, `frame_start` = 0
  - `hsync_n` = 1, `vsync_n` = 1, `blank` = 1, with all delay stages also reset
- `rst` mid-frame: counters return to (0,0) on the next edge, and the pipeline flushes to reset values. A write in the same cycle as `rst` is still performed.
- `px_en` low: counters hold and `en` drops to 0 on the next edge. Other outputs hold their last values.

## Structure
- Package `video_pkg` holds the timing constants, COLS/ROWS/CELLS, and the typedefs `char_code_t` (4b) and `cell_addr_t` (12b). `character_generator` uses the same package.
- One sub-module, `char_ram`: a simple dual-port RAM with registered read and no reset, inferrable as block RAM.
- Raster counters, address computation and delay pipeline live in the top module.

## Test plan
- Reset, then `px_en` = 1 constant for one frame:
  - `frame_start` pulses once every 420000 clks.
  - `hsync_n` low for 96 clks starting 656+1+PIXEL_LAT clks after the line start.
  - `vsync_n` low for 2 lines.
- Write code 4'hA to addr 81 (row 1, col 1), then scan:
  - While `h_cnt` in 8..15 and `v_cnt` in 16..31, `character` = 4'hA one clk later.
  - Neighbouring cells read 0 once pre-written with 0.
- Write to addr 2400 and 4095: no RAM change; a readback scan shows all cells unchanged.
- `px_en` toggling 1,0,1,0:
  - Counters advance every other clk.
  - `en` pulses only on the clk after each `px_en` = 1 in the active area.
- Assert `rst` at (h=300, v=200):
  - Next edge: counters at (0,0), `en` = 0, `hsync_n` = `vsync_n` = 1, `blank` = 1.
  - Timing restarts cleanly and a new `frame_start` arrives after one full frame.
- Simultaneous write and read to the same cell: `character` shows the old code for that pixel and the new code on the next frame.

Source files
------------

// File: rtl/video_pkg.sv
// Shared VGA timing constants and character-cell types for the LC3 text video path.
package video_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int COLS = VGA_H_ACTIVE / 8;
    localparam int ROWS = VGA_V_ACTIVE / 16;

    typedef logic [3:0]  char_code_t;
    typedef logic [11:0] cell_addr_t;

    localparam cell_addr_t CELLS = 12'(COLS * ROWS);

endpackage

// File: rtl/char_ram.sv
// Character RAM: one write port, one registered read port, no reset (maps onto block RAM).
module char_ram
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  cell_addr_t wr_addr,
    input  char_code_t wr_data,
    input  logic       rd_en,
    input  cell_addr_t rd_addr,
    output char_code_t rd_data
);

    char_code_t mem [0:CELLS-1];

    // Read-before-write: a same-address read in the write cycle returns the old code.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < CELLS)) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/text_scan_controller.sv
// VGA raster generator and 80x30 text-cell scanner feeding character_generator.
module text_scan_controller
    import video_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int PIXEL_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       px_en,
    input  logic       wr_en,
    input  cell_addr_t wr_addr,
    input  char_code_t wr_data,
    output char_code_t character,
    output logic [2:0] dot_count,
    output logic [3:0] scan_count,
    output logic       en,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       blank,
    output logic       frame_start
);

    localparam int DLY = 1 + PIXEL_LAT;

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt_p0;
    logic [9:0] v_cnt_p0;
    logic       h_wrap_p0;
    logic       v_wrap_p0;
    logic       active_p0;
    logic       rd_en_p0;
    logic [6:0] col_p0;
    logic [4:0] row_p0;
    cell_addr_t rd_addr_p0;
    logic       hs_raw_p0;
    logic       vs_raw_p0;
    logic       bl_raw_p0;

    char_code_t     ram_q_p1;
    logic           char_vld_p1;
    logic [DLY-1:0] hs_dly;
    logic [DLY-1:0] vs_dly;
    logic [DLY-1:0] bl_dly;

    // ---- stage 0: raster counters and cell address ----
    assign h_wrap_p0 = (h_cnt_p0 == H_LAST);
    assign v_wrap_p0 = (v_cnt_p0 == V_LAST);
    assign active_p0 = (h_cnt_p0 < H_VIS) && (v_cnt_p0 < V_VIS);
    assign col_p0    = h_cnt_p0[9:3];
    assign row_p0    = v_cnt_p0[8:4];
    // row*80 + col as shifts: row*64 + row*16 + col
    assign rd_addr_p0 = (12'(row_p0) << 6) + (12'(row_p0) << 4) + 12'(col_p0);
    assign rd_en_p0   = px_en && active_p0 && !rst;

    assign hs_raw_p0 = !((h_cnt_p0 >= HS_FIRST) && (h_cnt_p0 <= HS_LAST));
    assign vs_raw_p0 = !((v_cnt_p0 >= VS_FIRST) && (v_cnt_p0 <= VS_LAST));
    assign bl_raw_p0 = !active_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= '0;
        end else if (px_en) begin
            if (h_wrap_p0) begin
                h_cnt_p0 <= '0;
                v_cnt_p0 <= v_wrap_p0 ? 10'd0 : v_cnt_p0 + 10'd1;
            end else begin
                h_cnt_p0 <= h_cnt_p0 + 10'd1;
            end
        end
    end

    char_ram u_char_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en_p0),
        .rd_addr (rd_addr_p0),
        .rd_data (ram_q_p1)
    );

    // ---- stage 1: registered cell fields, enable and frame marker ----
    always_ff @(posedge clk) begin
        if (rst) begin
            dot_count   <= '0;
            scan_count  <= '0;
            en          <= 1'b0;
            frame_start <= 1'b0;
            char_vld_p1 <= 1'b0;
        end else begin
            en          <= px_en && active_p0;
            frame_start <= px_en && h_wrap_p0 && v_wrap_p0;
            if (px_en) begin
                dot_count  <= h_cnt_p0[2:0];
                scan_count <= v_cnt_p0[3:0];
            end
            if (rd_en_p0) begin
                char_vld_p1 <= 1'b1;
            end
        end
    end

    // The RAM output has no reset, so mask it until a post-reset read has landed.
    assign character = char_vld_p1 ? ram_q_p1 : '0;

    // ---- sync/blank delay line, aligned with the generator's pixel ----
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_dly <= '1;
            vs_dly <= '1;
            bl_dly <= '1;
        end else if (px_en) begin
            hs_dly <= (hs_dly << 1) | DLY'(hs_raw_p0);
            vs_dly <= (vs_dly << 1) | DLY'(vs_raw_p0);
            bl_dly <= (bl_dly << 1) | DLY'(bl_raw_p0);
        end
    end

    assign hsync_n = hs_dly[DLY-1];
    assign vsync_n = vs_dly[DLY-1];
    assign blank   = bl_dly[DLY-1];

endmodule
